// File: rtl/conv_seq.sv
// conv_seq: job sequencer for a small convolution PE array.
// Streams ifmap bytes then filter bytes from one upstream valid/ready port
// into two serial loaders. It then waits for the array to settle, drains
// the serialized result bytes, and pulses done when the job is finished.
//
// Handshake: an upstream byte transfers on every rising edge where
// in_valid && in_ready. in_ready is a pure decode of the registered state
// and never depends on in_valid. The outputs out_valid/out_data have no
// backpressure.
module conv_seq #(
    parameter int IFMAP_BYTES    = 25,
    parameter int FILTER_BYTES   = 9,
    parameter int COMPUTE_CYCLES = 3,
    parameter int OUT_BYTES      = 9
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       start,
    input  logic       in_valid,
    input  logic [7:0] in_data,
    output logic       in_ready,
    output logic [7:0] ifmap_byte,
    output logic [7:0] filter_byte,
    output logic       done_serial1,
    output logic       done_serial2,
    output logic       done_para,
    input  logic [7:0] res_in,
    output logic       out_valid,
    output logic [7:0] out_data,
    output logic       busy,
    output logic       done,
    output logic [2:0] state_dbg
);

    // Counter must reach COMPUTE_CYCLES and OUT_BYTES, not only their minus-one.
    localparam int MAX_LOAD = (IFMAP_BYTES > FILTER_BYTES) ? IFMAP_BYTES : FILTER_BYTES;
    localparam int MAX_TAIL = (OUT_BYTES > COMPUTE_CYCLES) ? OUT_BYTES : COMPUTE_CYCLES;
    localparam int MAX_CNT  = (MAX_LOAD > MAX_TAIL) ? MAX_LOAD : MAX_TAIL;
    localparam int CW       = $clog2(MAX_CNT + 1);

    localparam logic [CW-1:0] IF_LAST   = CW'(IFMAP_BYTES - 1);
    localparam logic [CW-1:0] FLT_LAST  = CW'(FILTER_BYTES - 1);
    localparam logic [CW-1:0] COMP_LAST = CW'(COMPUTE_CYCLES);
    localparam logic [CW-1:0] OUT_LAST  = CW'(OUT_BYTES - 1);
    localparam logic [CW-1:0] OUT_END   = CW'(OUT_BYTES);

    typedef enum logic [2:0] {
        IDLE     = 3'd0,
        LOAD_IF  = 3'd1,
        LOAD_FLT = 3'd2,
        COMPUTE  = 3'd3,
        DRAIN    = 3'd4
    } state_t;

    state_t          state;
    logic   [CW-1:0] cnt;
    logic            beat;

    assign in_ready  = (state == LOAD_IF) || (state == LOAD_FLT);
    assign busy      = (state != IDLE);
    assign state_dbg = state;
    assign beat      = in_valid && in_ready;

    // Sequencer. COMPUTE is entered in the same cycle as the last filter
    // strobe, so it counts 0..COMPUTE_CYCLES. That leaves exactly
    // COMPUTE_CYCLES quiet cycles after the strobe. DRAIN stays one extra
    // cycle so the last registered out_valid lands before done and IDLE.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state        <= IDLE;
            cnt          <= '0;
            ifmap_byte   <= 8'h00;
            filter_byte  <= 8'h00;
            done_serial1 <= 1'b0;
            done_serial2 <= 1'b0;
            done_para    <= 1'b0;
            out_valid    <= 1'b0;
            out_data     <= 8'h00;
            done         <= 1'b0;
        end else begin
            done_serial1 <= 1'b0;
            done_serial2 <= 1'b0;
            done         <= 1'b0;
            out_valid    <= done_para;
            if (done_para) begin
                out_data <= res_in;
            end
            unique case (state)
                IDLE: begin
                    if (start) begin
                        state <= LOAD_IF;
                        cnt   <= '0;
                    end
                end
                LOAD_IF: begin
                    if (beat) begin
                        ifmap_byte   <= in_data;
                        done_serial1 <= 1'b1;
                        if (cnt == IF_LAST) begin
                            state <= LOAD_FLT;
                            cnt   <= '0;
                        end else begin
                            cnt <= cnt + 1'b1;
                        end
                    end
                end
                LOAD_FLT: begin
                    if (beat) begin
                        filter_byte  <= in_data;
                        done_serial2 <= 1'b1;
                        if (cnt == FLT_LAST) begin
                            state <= COMPUTE;
                            cnt   <= '0;
                        end else begin
                            cnt <= cnt + 1'b1;
                        end
                    end
                end
                COMPUTE: begin
                    if (cnt == COMP_LAST) begin
                        state     <= DRAIN;
                        cnt       <= '0;
                        done_para <= 1'b1;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                DRAIN: begin
                    if (cnt == OUT_LAST) begin
                        done_para <= 1'b0;
                    end
                    if (cnt == OUT_END) begin
                        state <= IDLE;
                        cnt   <= '0;
                        done  <= 1'b1;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                default: begin
                    state <= IDLE;
                    cnt   <= '0;
                end
            endcase
        end
    end

endmodule
